// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker for a Fibonacci LFSR bit stream.
// Hunts for WIDTH bits to seed a local LFSR, verifies LOCK_COUNT consecutive
// predicted bits, then flywheels in LOCKED and counts mismatches.
// Optional build macro PRBS_CHK_BITCNT_EN adds a 16-bit count of bits accepted in LOCKED.
module prbs_checker #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS       = 'hB8,
  parameter int unsigned     LOCK_COUNT  = 16,
  parameter int unsigned     LOSS_THRESH = 4,
  parameter int unsigned     ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [15:0]      bit_count
`endif
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned BAD_W   = 4;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sr_q;
  logic [FILL_W-1:0]  fill_q;
  logic [MATCH_W-1:0] match_q;
  logic [BAD_W-1:0]   bad_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_count_q;

  logic             pred_bit;
  logic             mismatch;
  logic [WIDTH-1:0] sr_resync;
  logic             fill_done;
  logic             match_done;
  logic             loss_done;
  logic             err_sat;

  // Prediction and compare against the incoming bit.
  always_comb begin
    pred_bit   = ^(sr_q & TAPS);
    mismatch   = bit_in ^ pred_bit;
    sr_resync  = {sr_q[WIDTH-2:0], bit_in};
    fill_done  = (fill_q == FILL_W'(WIDTH - 1));
    match_done = (match_q == MATCH_W'(LOCK_COUNT - 1));
    loss_done  = (bad_q == BAD_W'(LOSS_THRESH - 1));
    err_sat    = &err_count_q;
  end

  // Hunt/check/locked FSM with its counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      // Clear wins over any increment below (the increment is gated by clr_cnt).
      if (clr_cnt) begin
        err_count_q <= '0;
      end
      if (bit_valid) begin
        unique case (state_q)
          StHunt: begin
            sr_q <= sr_resync;
            if (fill_done) begin
              state_q <= StCheck;
              fill_q  <= '0;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          StCheck: begin
            // Keep resyncing to the line while verifying the prediction.
            sr_q <= sr_resync;
            if (sr_resync == '0) begin
              state_q <= StHunt;
              fill_q  <= '0;
              match_q <= '0;
            end else if (mismatch) begin
              match_q <= '0;
            end else if (match_done) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
              match_q  <= '0;
              bad_q    <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          StLocked: begin
            // Flywheel: a corrupted line bit never enters the register.
            sr_q <= {sr_q[WIDTH-2:0], pred_bit};
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (!clr_cnt && !err_sat) begin
                err_count_q <= err_count_q + 1'b1;
              end
              if (loss_done) begin
                state_q  <= StHunt;
                locked_q <= 1'b0;
                fill_q   <= '0;
                bad_q    <= '0;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end else begin
              bad_q <= '0;
            end
          end
          default: begin
            state_q  <= StHunt;
            locked_q <= 1'b0;
            fill_q   <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_o   = state_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [15:0] bit_count_q;

  // Saturating count of bits accepted while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count_q <= '0;
    end else if (clr_cnt) begin
      bit_count_q <= '0;
    end else if (bit_valid && (state_q == StLocked) && !(&bit_count_q)) begin
      bit_count_q <= bit_count_q + 1'b1;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: default build plus an ERR_W=4 instance for saturation.
module tb_prbs_checker;

  localparam logic [7:0] TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       locked, locked4;
  logic       err_pulse, err_pulse4;
  logic [7:0] err_count;
  logic [3:0] err_count4;
  logic [1:0] state_o, state_o4;
`ifdef PRBS_CHK_BITCNT_EN
  logic [15:0] bit_count, bit_count4;
`endif

  prbs_checker dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .state_o  (state_o)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_count(bit_count)
`endif
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked4),
    .err_pulse(err_pulse4),
    .err_count(err_count4),
    .state_o  (state_o4)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_count(bit_count4)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       lk;
    logic       pl;
    logic [7:0] c8;
    logic [3:0] c4;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_errs = 0;
  logic [7:0]  gen = 8'h01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"},     32'(locked),     32'd0);
    check({tag, " err_pulse"},  32'(err_pulse),  32'd0);
    check({tag, " err_count"},  32'(err_count),  32'd0);
    check({tag, " state"},      32'(state_o),    32'd0);
    check({tag, " locked4"},    32'(locked4),    32'd0);
    check({tag, " err_count4"}, 32'(err_count4), 32'd0);
  endtask

  // Drive one cycle; flip corrupts the generated bit on the line.
  task automatic step(input bit valid, input bit flip, input bit clr,
                      input logic [1:0] est, input bit epulse);
    logic b;
    exp_t e;
    @(negedge clk);
    bit_valid = valid;
    clr_cnt   = clr;
    if (valid) begin
      b      = ^(gen & TAPS);
      gen    = {gen[6:0], b};
      bit_in = b ^ flip;
    end else begin
      bit_in = 1'($urandom_range(0, 1));
    end
    if (clr) exp_errs = 0;
    else if (epulse) exp_errs++;
    e.st = est;
    e.lk = (est == 2'd2);
    e.pl = epulse;
    e.c8 = (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
    e.c4 = (exp_errs > 15) ? 4'hF : 4'(exp_errs);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("state",      32'(state_o),    32'(e.st));
    check("locked",     32'(locked),     32'(e.lk));
    check("err_pulse",  32'(err_pulse),  32'(e.pl));
    check("err_count",  32'(err_count),  32'(e.c8));
    check("state4",     32'(state_o4),   32'(e.st));
    check("err_pulse4", 32'(err_pulse4), 32'(e.pl));
    check("err_count4", 32'(err_count4), 32'(e.c4));
  endtask

  function automatic logic [1:0] acq_state(input int k);
    return (k < 8) ? 2'd0 : (k < 24) ? 2'd1 : 2'd2;
  endfunction

  initial begin
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean lock and 1000 error-free bits.
    for (int i = 1; i <= 1000; i++) step(1'b1, 1'b0, 1'b0, acq_state(i), 1'b0);

    // One corrupted bit while locked.
    for (int i = 1; i <= 200; i++) step(1'b1, (i == 100), 1'b0, 2'd2, (i == 100));

    // Clear, then four consecutive errors drop lock; reacquire after 24 good bits.
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, (i == 4) ? 2'd0 : 2'd2, 1'b1);
    for (int i = 1; i <= 34; i++) step(1'b1, 1'b0, 1'b0, acq_state(i), 1'b0);

    // Fifth error, then asynchronous reset between clock edges.
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    check("pre-reset err_count", 32'(err_count), 32'd5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("async reset");
    bit_valid = 1'b0;
    exp_errs  = 0;
    gen       = 8'h01;
    @(negedge clk);
    rst = 1'b0;

    // Gapped valid: every other cycle idle with random line data.
    begin
      int k;
      k = 0;
      for (int c = 0; c < 120; c++) begin
        if (c % 2 == 0) k++;
        step((c % 2 == 0), 1'b0, 1'b0, acq_state(k), 1'b0);
      end
    end

    // Twenty isolated errors saturate the 4-bit counter.
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
      for (int j = 0; j < 5; j++) step(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    end
    check("sat err_count4", 32'(err_count4), 32'd15);
    check("sat err_count",  32'(err_count),  32'd20);

    // Clear coincident with an error: count 0, pulse still fires.
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
